// File: rtl/is_launch_ctrl.sv
// Dual-issue launch controller: picks double/single/zero launch from the two FIFO heads and registers the launched pair.
// Optional LAUNCH_PERF_CNT_EN adds per-flag performance counters.
module is_launch_ctrl #(
  parameter int unsigned LINE_W  = 128,
  parameter bit          DUAL_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_i,
  input  logic                  line1_fifo_valid_i,
  input  logic                  line2_fifo_valid_i,
  input  logic [2*LINE_W-1:0]   fifo_to_now_ibus,
  output logic                  double_valid_inst_lunch_flag_o,
  output logic                  single_valid_inst_lunch_flag_o,
  output logic                  zero_valid_inst_lunch_flag_o,
  input  logic                  next_allowin_i,
  output logic                  line1_now_valid_o,
  output logic                  line2_now_valid_o,
  output logic [2*LINE_W-1:0]   now_to_next_obus,
  input  logic                  load_done_i,
  input  logic [4:0]            load_rd_i
`ifdef LAUNCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_double_cnt_o,
  output logic [31:0]           perf_single_cnt_o,
  output logic [31:0]           perf_zero_cnt_o
`endif
);

  localparam int unsigned REG_N = 32;

  logic [LINE_W-1:0] l1, l2;
  logic [4:0]        l1_rd, l1_rj, l1_rk, l2_rd, l2_rj, l2_rk;
  logic              l1_we, l1_rje, l1_rke, l1_ld, l1_br;
  logic              l2_we, l2_rje, l2_rke, l2_ld, l2_br, l2_s1o;
  logic [REG_N-1:0]  busy, set_mask, clr_mask;
  logic              now_allowin, l1_haz, l2_haz, l1_wr, l2_raw, waw, single_cond;
  logic              launch1, launch2;

  assign l1 = fifo_to_now_ibus[LINE_W-1:0];
  assign l2 = fifo_to_now_ibus[2*LINE_W-1:LINE_W];

  assign l1_rd  = l1[4:0];   assign l1_we  = l1[5];
  assign l1_rj  = l1[10:6];  assign l1_rje = l1[11];
  assign l1_rk  = l1[16:12]; assign l1_rke = l1[17];
  assign l1_ld  = l1[18];    assign l1_br  = l1[19];
  assign l2_rd  = l2[4:0];   assign l2_we  = l2[5];
  assign l2_rj  = l2[10:6];  assign l2_rje = l2[11];
  assign l2_rk  = l2[16:12]; assign l2_rke = l2[17];
  assign l2_ld  = l2[18];    assign l2_br  = l2[19];
  assign l2_s1o = l2[20];

  assign now_allowin = ~line1_now_valid_o | next_allowin_i;

  // Load-use hazards against the outstanding-load scoreboard
  assign l1_haz = line1_fifo_valid_i & ((l1_rje & busy[l1_rj]) | (l1_rke & busy[l1_rk]));
  assign l2_haz = line2_fifo_valid_i & ((l2_rje & busy[l2_rj]) | (l2_rke & busy[l2_rk]));

  // Intra-pair conflicts that force line2 to wait
  assign l1_wr  = l1_we & (l1_rd != 5'd0);
  assign l2_raw = l1_wr & ((l2_rje & (l2_rj == l1_rd)) | (l2_rke & (l2_rk == l1_rd)));
  assign waw    = l1_wr & l2_we & (l2_rd == l1_rd);

  assign single_cond = ~DUAL_EN | ~line2_fifo_valid_i | l2_haz | l1_br | l2_s1o | l2_br
                     | l2_raw | waw | (l1_ld & l2_ld);

  always_comb begin
    zero_valid_inst_lunch_flag_o   = 1'b0;
    single_valid_inst_lunch_flag_o = 1'b0;
    double_valid_inst_lunch_flag_o = 1'b0;
    if (!reset && !flush_i) begin
      if (!now_allowin || !line1_fifo_valid_i || l1_haz)
        zero_valid_inst_lunch_flag_o = 1'b1;
      else if (single_cond)
        single_valid_inst_lunch_flag_o = 1'b1;
      else
        double_valid_inst_lunch_flag_o = 1'b1;
    end
  end

  assign launch1 = single_valid_inst_lunch_flag_o | double_valid_inst_lunch_flag_o;
  assign launch2 = double_valid_inst_lunch_flag_o;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (launch1 && l1_ld && l1_wr) set_mask = set_mask | (32'd1 << l1_rd);
    if (launch2 && l2_ld && l2_we && (l2_rd != 5'd0)) set_mask = set_mask | (32'd1 << l2_rd);
    if (load_done_i) clr_mask = 32'd1 << load_rd_i;
  end

  // Scoreboard: set wins over a same-cycle clear; r0 never busy
  always_ff @(posedge clk) begin
    if (reset || flush_i) busy <= '0;
    else                  busy <= ((busy & ~clr_mask) | set_mask) & ~32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      line1_now_valid_o <= 1'b0;
      line2_now_valid_o <= 1'b0;
      now_to_next_obus  <= '0;
    end else if (now_allowin) begin
      line1_now_valid_o <= launch1;
      line2_now_valid_o <= launch2;
      now_to_next_obus  <= {(launch2 ? l2 : LINE_W'(0)), (launch1 ? l1 : LINE_W'(0))};
    end
  end

`ifdef LAUNCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_double_cnt_o <= '0;
      perf_single_cnt_o <= '0;
      perf_zero_cnt_o   <= '0;
    end else if (line1_fifo_valid_i) begin
      if (double_valid_inst_lunch_flag_o) perf_double_cnt_o <= perf_double_cnt_o + 32'd1;
      if (single_valid_inst_lunch_flag_o) perf_single_cnt_o <= perf_single_cnt_o + 32'd1;
      if (zero_valid_inst_lunch_flag_o)   perf_zero_cnt_o   <= perf_zero_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_is_launch_ctrl.sv
// Scoreboard bench for is_launch_ctrl: directed pairs with hand-computed launch flags.
module tb_is_launch_ctrl;
  localparam int unsigned W = 128;

  logic clk = 1'b0;
  logic reset, flush_i, line1_fifo_valid_i, line2_fifo_valid_i, next_allowin_i;
  logic load_done_i;
  logic [4:0] load_rd_i;
  logic [2*W-1:0] fifo_to_now_ibus, now_to_next_obus;
  logic dbl, sgl, zro, v1, v2;
`ifdef LAUNCH_PERF_CNT_EN
  logic [31:0] pd, ps, pz;
`endif

  is_launch_ctrl #(.LINE_W(W), .DUAL_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .line1_fifo_valid_i(line1_fifo_valid_i), .line2_fifo_valid_i(line2_fifo_valid_i),
    .fifo_to_now_ibus(fifo_to_now_ibus),
    .double_valid_inst_lunch_flag_o(dbl), .single_valid_inst_lunch_flag_o(sgl),
    .zero_valid_inst_lunch_flag_o(zro), .next_allowin_i(next_allowin_i),
    .line1_now_valid_o(v1), .line2_now_valid_o(v2), .now_to_next_obus(now_to_next_obus),
    .load_done_i(load_done_i), .load_rd_i(load_rd_i)
`ifdef LAUNCH_PERF_CNT_EN
    , .perf_double_cnt_o(pd), .perf_single_cnt_o(ps), .perf_zero_cnt_o(pz)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int unsigned cyc; logic [2:0] f; } fexp_t;
  typedef struct { int unsigned cyc; logic v1; logic v2; logic [2*W-1:0] bus; } oexp_t;
  fexp_t fq[$];
  oexp_t oq[$];
  int passed = 0, total = 0;

  // Expected output register state
  logic m_v1 = 1'b0, m_v2 = 1'b0;
  logic [2*W-1:0] m_bus = '0;

  localparam int N = 0, Z = 1, S = 2, D = 3;

  function automatic logic [W-1:0] mk(input int rd, input bit we, input int rj, input bit rje,
                                      input int rk, input bit rke, input bit ld, input bit br,
                                      input bit s1, input logic [31:0] tag);
    logic [W-1:0] v;
    v = '0;
    v[4:0] = 5'(rd); v[5] = we; v[10:6] = 5'(rj); v[11] = rje;
    v[16:12] = 5'(rk); v[17] = rke; v[18] = ld; v[19] = br; v[20] = s1;
    v[W-1 -: 32] = tag;
    v[63:32] = ~tag;
    return v;
  endfunction

  task automatic step(input bit rst, input bit fl, input bit a_v, input bit b_v,
                      input logic [W-1:0] a, input logic [W-1:0] b, input bit nxt,
                      input bit ld, input int ldrd, input int ef);
    fexp_t fe;
    oexp_t oe;
    reset = rst; flush_i = fl; line1_fifo_valid_i = a_v; line2_fifo_valid_i = b_v;
    fifo_to_now_ibus = {b, a}; next_allowin_i = nxt; load_done_i = ld; load_rd_i = 5'(ldrd);
    fe.cyc = cyc;
    fe.f = (ef == D) ? 3'b100 : (ef == S) ? 3'b010 : (ef == Z) ? 3'b001 : 3'b000;
    fq.push_back(fe);
    if (rst || fl) begin
      m_v1 = 1'b0; m_v2 = 1'b0; m_bus = '0;
    end else if (!m_v1 || nxt) begin
      m_v1 = (ef == S) || (ef == D);
      m_v2 = (ef == D);
      m_bus = {(ef == D) ? b : W'(0), m_v1 ? a : W'(0)};
    end
    oe.cyc = cyc + 1; oe.v1 = m_v1; oe.v2 = m_v2; oe.bus = m_bus;
    oq.push_back(oe);
    @(posedge clk); #1;
  endtask

  // Monitor: compare whatever the DUT presents against queued expectations for this cycle
  always @(negedge clk) begin
    while (fq.size() > 0 && fq[0].cyc == cyc) begin
      fexp_t e;
      e = fq.pop_front();
      total++;
      if ({dbl, sgl, zro} === e.f) passed++;
      else $display("FAIL flags cyc=%0d got dsz=%b exp=%b", cyc, {dbl, sgl, zro}, e.f);
    end
    while (oq.size() > 0 && oq[0].cyc == cyc) begin
      oexp_t e;
      e = oq.pop_front();
      total++;
      if ({v1, v2} === {e.v1, e.v2} && now_to_next_obus === e.bus) passed++;
      else $display("FAIL out cyc=%0d got v=%b%b bus=%h exp v=%b%b bus=%h",
                    cyc, v1, v2, now_to_next_obus, e.v1, e.v2, e.bus);
    end
  end

  logic [W-1:0] x0, a, b, c;

  initial begin
    reset = 1'b1; flush_i = 1'b0; line1_fifo_valid_i = 1'b0; line2_fifo_valid_i = 1'b0;
    fifo_to_now_ibus = '0; next_allowin_i = 1'b1; load_done_i = 1'b0; load_rd_i = '0;
    x0 = '0;
    @(posedge clk); #1;
    a = mk(3, 1, 1, 1, 2, 1, 0, 0, 0, 32'hA0000001);
    b = mk(8, 1, 5, 1, 6, 1, 0, 0, 0, 32'hA0000002);
    step(1, 0, 1, 1, a, b, 1, 0, 0, N);                      // reset: flags and outputs 0
    step(0, 0, 1, 1, a, b, 1, 0, 0, D);                      // independent pair
    step(0, 0, 1, 1, mk(3, 1, 0, 0, 0, 0, 0, 0, 0, 32'hB1),
                     mk(9, 1, 3, 1, 0, 0, 0, 0, 0, 32'hB2), 1, 0, 0, S);   // RAW in pair
    step(0, 0, 1, 0, mk(4, 1, 0, 0, 0, 0, 1, 0, 0, 32'hC1), x0, 1, 0, 0, S); // load r4
    a = mk(10, 1, 4, 1, 0, 0, 0, 0, 0, 32'hD1);
    b = mk(11, 1, 12, 1, 0, 0, 0, 0, 0, 32'hD2);
    repeat (3) step(0, 0, 1, 1, a, b, 1, 0, 0, Z);           // load-use stall
    step(0, 0, 1, 1, a, b, 1, 1, 4, Z);                      // writeback cycle still stalls
    step(0, 0, 1, 1, a, b, 1, 0, 0, D);                      // released
    step(0, 0, 1, 0, mk(7, 1, 0, 0, 0, 0, 1, 0, 0, 32'hE0), x0, 1, 0, 0, S);
    step(0, 0, 1, 0, mk(7, 1, 0, 0, 0, 0, 1, 0, 0, 32'hE1), x0, 1, 1, 7, S); // set beats clear
    c = mk(18, 1, 0, 0, 7, 1, 0, 0, 0, 32'hF1);
    step(0, 0, 1, 0, c, x0, 1, 0, 0, Z);
    step(0, 0, 1, 0, c, x0, 1, 1, 7, Z);
    step(0, 0, 1, 0, c, x0, 1, 0, 0, S);
    step(0, 0, 1, 1, mk(12, 1, 1, 1, 0, 0, 0, 0, 0, 32'h61),
                     mk(13, 1, 2, 1, 0, 0, 0, 0, 0, 32'h62), 1, 0, 0, D);
    a = mk(19, 1, 0, 0, 0, 0, 0, 0, 0, 32'h71);
    b = mk(20, 1, 0, 0, 0, 0, 0, 0, 0, 32'h72);
    repeat (3) step(0, 0, 1, 1, a, b, 0, 0, 0, Z);           // backpressure: hold
    step(0, 0, 1, 1, a, b, 1, 0, 0, D);
    step(0, 0, 1, 1, mk(0, 0, 1, 1, 0, 0, 0, 1, 0, 32'h81),
                     mk(21, 1, 0, 0, 0, 0, 0, 0, 0, 32'h82), 1, 0, 0, S); // line1 branch
    step(0, 0, 1, 1, mk(16, 1, 0, 0, 0, 0, 0, 0, 0, 32'h91),
                     mk(22, 1, 0, 0, 0, 0, 0, 0, 1, 32'h92), 1, 0, 0, S); // slot1_only
    step(0, 0, 1, 1, mk(17, 1, 0, 0, 0, 0, 0, 0, 0, 32'h93),
                     mk(17, 1, 0, 0, 0, 0, 0, 0, 0, 32'h94), 1, 0, 0, S); // same rd
    step(0, 0, 1, 1, mk(14, 1, 0, 0, 0, 0, 1, 0, 0, 32'h95),
                     mk(15, 1, 0, 0, 0, 0, 1, 0, 0, 32'h96), 1, 0, 0, S); // two loads
    step(0, 0, 1, 0, mk(9, 1, 0, 0, 0, 0, 1, 0, 0, 32'h97), x0, 1, 0, 0, S); // load r9
    step(0, 0, 1, 1, mk(23, 1, 1, 1, 0, 0, 0, 0, 0, 32'h98),
                     mk(24, 1, 0, 0, 0, 0, 0, 0, 0, 32'h99), 1, 0, 0, D);
    step(0, 1, 1, 1, mk(25, 1, 0, 0, 0, 0, 0, 0, 0, 32'h9A),
                     mk(26, 1, 0, 0, 0, 0, 0, 0, 0, 32'h9B), 1, 1, 9, N); // flush
    step(0, 0, 1, 0, mk(27, 1, 9, 1, 0, 0, 0, 0, 0, 32'h9C), x0, 1, 0, 0, S); // busy cleared
    line1_fifo_valid_i = 1'b0; line2_fifo_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (fq.size() != 0 || oq.size() != 0) begin
      total++;
      $display("FAIL drain got %0d/%0d pending exp 0/0", fq.size(), oq.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
